// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard event sequencer.
package kbd_pkg;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } kbd_evt_t;

  typedef struct packed {
    logic       valid;
    logic       ext;
    logic [7:0] code;
  } kbd_held_t;

  localparam logic [7:0] KBD_PFX_EXT = 8'hE0;
  localparam logic [7:0] KBD_PFX_REL = 8'hF0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_POP  = 1'b1
  } kbd_ctrl_state_t;

  // A make event that repeats the key already held down.
  function automatic logic is_repeat(input kbd_held_t h, input kbd_evt_t e);
    return h.valid && !e.rel && (h.ext == e.ext) && (h.code == e.code);
  endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// Synchronous FIFO of decoded key events; head entry reads as zero when empty.
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   push,
  input  logic                   pop,
  input  kbd_evt_t               din,
  output kbd_evt_t               dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  kbd_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? kbd_evt_t'('0) : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/kbd_event_ctrl.sv
// Pops PS/2 scan-code bytes, folds E0/F0 prefixes into key events and
// buffers them for a single valid/ready consumer.
module kbd_event_ctrl
  import kbd_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter bit FILTER_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       en,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_rel,
  output logic       ovf_flag,
  input  logic       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

  kbd_ctrl_state_t state;
  logic [7:0]      byte_q;
  logic            ext_f;
  logic            rel_f;
  kbd_held_t       held;

  kbd_evt_t        dec_evt;
  kbd_evt_t        head;
  logic            pop_go;
  logic            is_pfx;
  logic            filt_drop;
  logic            evt_push;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;

  // Pop only when the event FIFO can still take whatever this byte yields;
  // an overflow cycle never pops so the byte is not silently discarded.
  assign pop_go = clrn && en && kb_ready && !kb_overflow &&
                  (fifo_count < CNT_DEPTH) && (state == S_IDLE);
  assign kb_nextdata_n = !pop_go;

  assign dec_evt   = '{ext: ext_f, rel: rel_f, code: byte_q};
  assign is_pfx    = (byte_q == KBD_PFX_EXT) || (byte_q == KBD_PFX_REL);
  assign filt_drop = FILTER_REPEAT && is_repeat(held, dec_evt);
  assign evt_push  = (state == S_POP) && !kb_overflow && !is_pfx &&
                     !filt_drop && !fifo_full;

  // Stage 1: byte capture at the pop edge
  always_ff @(posedge clk) begin
    if (pop_go) byte_q <= kb_data;
  end

  // Stage 2: decode of the captured byte, prefix flags and held-key tracking
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= S_IDLE;
      ext_f <= 1'b0;
      rel_f <= 1'b0;
      held  <= '0;
    end else if (kb_overflow) begin
      state      <= S_IDLE;
      ext_f      <= 1'b0;
      rel_f      <= 1'b0;
      held.valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (pop_go) state <= S_POP;
        S_POP: begin
          state <= S_IDLE;
          if (byte_q == KBD_PFX_EXT) begin
            ext_f <= 1'b1;
          end else if (byte_q == KBD_PFX_REL) begin
            rel_f <= 1'b1;
          end else begin
            ext_f <= 1'b0;
            rel_f <= 1'b0;
            if (FILTER_REPEAT) begin
              if (!dec_evt.rel && !filt_drop)
                held <= '{valid: 1'b1, ext: ext_f, code: byte_q};
              else if (dec_evt.rel && (held.ext == ext_f) && (held.code == byte_q))
                held.valid <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Set beats clear when both arrive together.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)            ovf_flag <= 1'b0;
    else if (kb_overflow) ovf_flag <= 1'b1;
    else if (ovf_clr)     ovf_flag <= 1'b0;
  end

  // Stage 3: event buffering towards the consumer
  kbd_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (evt_push),
    .pop   (evt_valid && evt_ready),
    .din   (dec_evt),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign evt_valid = !fifo_empty;
  assign {evt_ext, evt_rel, evt_code} = head;

endmodule

// File: doc/kbd_event_ctrl.md
# kbd_event_ctrl

Sequencer for the PS/2 keyboard byte FIFO (`ps2_keyboard`). It pops raw scan-code bytes with the `nextdata_n` handshake and folds `E0`/`F0` prefixes into single key events. Completed events are buffered in a small event FIFO and offered to one consumer through a valid/ready interface. It replaces ad-hoc per-consumer prefix decoding and sits between `ps2_keyboard` and the CPU-side keyboard MMIO/terminal logic.

## Interface
Parameters:
- `DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `FILTER_REPEAT`, 1: 1 = suppress typematic repeats of the currently held make code.

Ports:
- `clk`  in  1  system clock.
- `clrn`  in  1  reset, asynchronous, active-low.
- `en`  in  1  1 = consume bytes; 0 = stop popping (`kb_nextdata_n` held 1), FSM state retained.
- `kb_data`  in  8  byte at head of `ps2_keyboard` FIFO.
- `kb_ready`  in  1  `ps2_keyboard` FIFO non-empty.
- `kb_overflow`  in  1  `ps2_keyboard` FIFO overflow.
- `kb_nextdata_n`  out  1  active-low pop strobe to `ps2_keyboard`.
- `evt_valid`  out  1  event FIFO non-empty.
- `evt_ready`  in  1  consumer accepts the head event.
- `evt_code`  out  8  scan code (no prefix).
- `evt_ext`  out  1  event carried an `E0` prefix.
- `evt_rel`  out  1  event carried an `F0` prefix (break).
- `ovf_flag`  out  1  sticky overflow indicator.
- `ovf_clr`  in  1  clears `ovf_flag`.

## Operation
FSM with two states, `S_IDLE` and `S_POP`:
- **`S_IDLE`:** if `en && kb_ready && count < DEPTH`, latch `kb_data` into `byte_q`, drive `kb_nextdata_n=0` for this cycle, and go to `S_POP`. Otherwise stay, with `kb_nextdata_n=1`.
- **`S_POP`:** `kb_nextdata_n=1`, decode `byte_q`, then return to `S_IDLE`. This gives a one-cycle gap so `kb_ready` reflects the popped pointer before the next pop.

Decode of `byte_q`:
- `E0`: set `ext_f`.
- `F0`: set `rel_f`.
- Any other byte forms the event `{ext_f, rel_f, byte_q}`, which is pushed unless filtered. It clears `ext_f` and `rel_f`.

Repeat filter (only when `FILTER_REPEAT=1`):
- Register `held = {valid, ext, code}`.
- A make event equal to `held` is dropped.
- A make event different from `held` is pushed and loads `held`.
- A break event matching `held.ext/code` clears `held.valid`.
- All break events are pushed.

Backpressure:
- A pop occurs only when the FIFO has space, so no event is ever lost.
- Prefix bytes are also gated by the space check.

Overflow:
- `kb_overflow=1` in any cycle sets `ovf_flag`, clears `ext_f`, `rel_f` and `held.valid`, and forces `S_IDLE`.
- The FIFO contents are kept.
- If `ovf_clr` and `kb_overflow` are both high in the same cycle, set wins.

Event FIFO:
- `evt_*` outputs show the head entry.
- A pop happens when `evt_valid && evt_ready`.
- Push and pop in the same cycle leave `count` unchanged.
- Pointers wrap modulo `DEPTH`.
- `count` is `$clog2(DEPTH)+1` bits wide.

Reset values: FSM `S_IDLE`, `kb_nextdata_n=1`, `evt_valid=0`, `evt_code=0`, `evt_ext=0`, `evt_rel=0`, `ovf_flag=0`, all flags cleared, FIFO empty.

## Timing
- A byte is consumed every 2 cycles at most.
- A push at the `S_POP` edge gives `evt_valid=1` on the following cycle.
- Latency from `kb_ready` rising with a complete 1-byte code to `evt_valid`: 2 cycles.
- `E0 F0 xx` needs 3 bytes, i.e. 6 cycles from the first `kb_ready`.
- `en` falling during `S_POP`: the decode still completes, then the FSM stays in `S_IDLE`.
- Reset asserted mid-sequence: immediate asynchronous clear of everything. A prefix byte already popped is lost by design.

## Structure
- Package `kbd_pkg`:
  - `typedef struct packed {logic ext; logic rel; logic [7:0] code;} kbd_evt_t`
  - constants `KBD_PFX_EXT=8'hE0`, `KBD_PFX_REL=8'hF0`
  - FSM state enum `kbd_ctrl_state_t`
- Sub-module `kbd_evt_fifo`: synchronous `kbd_evt_t` FIFO parameterised by `DEPTH`, with push, pop, full, empty and count.

## Test plan
- Bytes `1C`, `F0 1C` → events `{0,0,1C}` then `{0,1,1C}`; `kb_nextdata_n` pulses low exactly 3 times, each pulse 1 cycle wide.
- Bytes `E0 F0 75` → single event `{1,1,75}`, `evt_valid` rising 6 cycles after the first `kb_ready`.
- With `FILTER_REPEAT=1`, bytes `1C 1C 1C F0 1C 1C` → events `{0,0,1C}`, `{0,1,1C}`, `{0,0,1C}`.
- With `DEPTH=4` and `evt_ready=0`, 6 make codes queued upstream → 4 events stored and `kb_nextdata_n` stays 1 afterwards. Raising `evt_ready` drains all 6 in order.
- Pulse `kb_overflow` after `E0`, then send `1C` → event `{0,0,1C}` and `ovf_flag=1` until `ovf_clr`. With `ovf_clr` and `kb_overflow` both high, `ovf_flag` stays 1.
- Assert `clrn=0` mid `E0 F0` → all outputs at their reset values immediately; after release, byte `74` → event `{0,0,74}`.
